// File: rtl/adc_sar_if.sv
// Handshake and conversion-result bundle between the SAR ADC sequencer and its user.
// The master drives the request and the comparator; the slave (the sequencer) drives everything else.
interface adc_sar_if;
    logic       sample_req;
    logic       comp_in;
    logic       ch_sel;
    logic       sample_hold;
    logic [6:0] dac_code;
    logic [6:0] m_sense;
    logic [6:0] m_thresh;
    logic       data_valid;
    logic       busy;

    modport master (
        output sample_req,
        output comp_in,
        input  ch_sel,
        input  sample_hold,
        input  dac_code,
        input  m_sense,
        input  m_thresh,
        input  data_valid,
        input  busy
    );

    modport slave (
        input  sample_req,
        input  comp_in,
        output ch_sel,
        output sample_hold,
        output dac_code,
        output m_sense,
        output m_thresh,
        output data_valid,
        output busy
    );
endinterface

// File: rtl/adc_sar_ctrl.sv
// Two-channel 7-bit successive-approximation ADC sequencer: settles the mux, runs seven bit
// trials per channel, and publishes the moisture and threshold codes together.
module adc_sar_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int BIT_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    adc_sar_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        TRIAL  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] BIT_LAST    = 4'(BIT_CYCLES - 1);

    // One-hot weight of the SAR bit under trial.
    function automatic logic [6:0] bit_mask(input logic [2:0] idx);
        return 7'h01 << idx;
    endfunction

    state_t     state_r, state_s;
    logic [3:0] cnt_r, cnt_s;
    logic [2:0] bit_r, bit_s;
    logic [6:0] acc_r, acc_s;
    logic       ch_sel_r, ch_sel_s;
    logic       sample_hold_r, sample_hold_s;
    logic [6:0] dac_code_r, dac_code_s;
    logic [6:0] m_sense_r, m_sense_s;
    logic [6:0] m_thresh_r, m_thresh_s;
    logic       data_valid_r, data_valid_s;
    logic       busy_r, busy_s;
    logic [6:0] decided_s;

    // Accumulator value once the comparator verdict for the current bit is folded in.
    assign decided_s = bus.comp_in ? (acc_r | bit_mask(bit_r)) : acc_r;

    // State and output registers; reset leaves a "wet" moisture reading so nothing waters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= 4'd0;
            bit_r         <= 3'd0;
            acc_r         <= 7'h00;
            ch_sel_r      <= 1'b0;
            sample_hold_r <= 1'b0;
            dac_code_r    <= 7'h00;
            m_sense_r     <= 7'h7F;
            m_thresh_r    <= 7'h00;
            data_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            bit_r         <= bit_s;
            acc_r         <= acc_s;
            ch_sel_r      <= ch_sel_s;
            sample_hold_r <= sample_hold_s;
            dac_code_r    <= dac_code_s;
            m_sense_r     <= m_sense_s;
            m_thresh_r    <= m_thresh_s;
            data_valid_r  <= data_valid_s;
            busy_r        <= busy_s;
        end
    end

    // Next-state and next-output decode for the scan sequencer.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        bit_s         = bit_r;
        acc_s         = acc_r;
        ch_sel_s      = ch_sel_r;
        sample_hold_s = sample_hold_r;
        dac_code_s    = dac_code_r;
        m_sense_s     = m_sense_r;
        m_thresh_s    = m_thresh_r;
        data_valid_s  = 1'b0;
        busy_s        = busy_r;

        case (state_r)
            IDLE: begin
                ch_sel_s   = 1'b0;
                dac_code_s = 7'h00;
                acc_s      = 7'h00;
                cnt_s      = 4'd0;
                if (bus.sample_req) begin
                    state_s       = SETTLE;
                    sample_hold_s = 1'b1;
                    busy_s        = 1'b1;
                end else begin
                    sample_hold_s = 1'b0;
                    busy_s        = 1'b0;
                end
            end

            SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s       = TRIAL;
                    cnt_s         = 4'd0;
                    bit_s         = 3'd6;
                    sample_hold_s = 1'b0;
                    dac_code_s    = acc_r | bit_mask(3'd6);
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end

            TRIAL: begin
                // The comparator is trusted only at the end of the DAC settle window.
                if (cnt_r == BIT_LAST) begin
                    cnt_s = 4'd0;
                    if (bit_r == 3'd0) begin
                        acc_s      = 7'h00;
                        dac_code_s = 7'h00;
                        if (ch_sel_r == 1'b0) begin
                            m_sense_s     = decided_s;
                            ch_sel_s      = 1'b1;
                            sample_hold_s = 1'b1;
                            state_s       = SETTLE;
                        end else begin
                            m_thresh_s    = decided_s;
                            data_valid_s  = 1'b1;
                            sample_hold_s = 1'b0;
                            state_s       = DONE;
                        end
                    end else begin
                        bit_s      = bit_r - 3'd1;
                        acc_s      = decided_s;
                        dac_code_s = decided_s | bit_mask(bit_r - 3'd1);
                    end
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end

            DONE: begin
                state_s       = IDLE;
                busy_s        = 1'b0;
                ch_sel_s      = 1'b0;
                sample_hold_s = 1'b0;
                dac_code_s    = 7'h00;
                acc_s         = 7'h00;
                cnt_s         = 4'd0;
            end

            default: begin
                state_s       = IDLE;
                busy_s        = 1'b0;
                ch_sel_s      = 1'b0;
                sample_hold_s = 1'b0;
                dac_code_s    = 7'h00;
                acc_s         = 7'h00;
                cnt_s         = 4'd0;
            end
        endcase
    end

    assign bus.ch_sel      = ch_sel_r;
    assign bus.sample_hold = sample_hold_r;
    assign bus.dac_code    = dac_code_r;
    assign bus.m_sense     = m_sense_r;
    assign bus.m_thresh    = m_thresh_r;
    assign bus.data_valid  = data_valid_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Scoreboard bench for adc_sar_ctrl: default-timing instance plus a 1/1-cycle instance,
// each driven by an ideal comparator model.
module tb_adc_sar_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    adc_sar_if ifa();
    adc_sar_if ifb();

    logic [6:0] va0, va1, vb0, vb1;

    assign ifa.comp_in = ((ifa.ch_sel ? va1 : va0) >= ifa.dac_code);
    assign ifb.comp_in = ((ifb.ch_sel ? vb1 : vb0) >= ifb.dac_code);

    adc_sar_ctrl #(.SETTLE_CYCLES(4), .BIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    adc_sar_ctrl #(.SETTLE_CYCLES(1), .BIT_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        int         dut;
        logic [6:0] sense;
        logic [6:0] thresh;
        int         cyc;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int idx, input logic [6:0] s, input logic [6:0] t);
        exp_t e;
        chk("dv_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("dv_dut",    32'(idx), 32'(e.dut));
            chk("dv_sense",  32'(s),   32'(e.sense));
            chk("dv_thresh", 32'(t),   32'(e.thresh));
            chk("dv_cycle",  32'(cyc), 32'(e.cyc));
        end
    endtask

    // Monitors: every data_valid pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && ifa.data_valid === 1'b1) mon(0, ifa.m_sense, ifa.m_thresh);
        if (rst === 1'b0 && ifb.data_valid === 1'b1) mon(1, ifb.m_sense, ifb.m_thresh);
    end

    // Channel-0 DAC trial code capture (distinct values in order).
    logic       cap = 1'b0;
    logic [6:0] last_code;
    logic [6:0] seq[$];
    always @(negedge clk) begin
        if (!cap) begin
            last_code = 7'h00;
        end else if (ifa.busy && !ifa.sample_hold && !ifa.ch_sel && ifa.dac_code != last_code) begin
            seq.push_back(ifa.dac_code);
            last_code = ifa.dac_code;
        end
    end

    // Caller sits on a negedge; the next posedge is the accepting edge.
    task automatic request(input int idx, input logic [6:0] es, input logic [6:0] et, input bit push);
        exp_t e;
        if (push) begin
            e.dut = idx; e.sense = es; e.thresh = et;
            e.cyc = cyc + ((idx == 0) ? 37 : 17);
            q.push_back(e);
        end
        if (idx == 0) ifa.sample_req = 1'b1; else ifb.sample_req = 1'b1;
        @(negedge clk);
        ifa.sample_req = 1'b0;
        ifb.sample_req = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int budget);
        int n = 0;
        while (((idx == 0) ? ifa.busy : ifb.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("scan_finishes", 32'((idx == 0) ? ifa.busy : ifb.busy), 32'd0);
    endtask

    logic [6:0] exp_seq [7];
    int n0;

    initial begin
        exp_seq = '{7'h40, 7'h60, 7'h70, 7'h78, 7'h7C, 7'h7E, 7'h7F};
        rst = 1'b1;
        ifa.sample_req = 1'b0;
        ifb.sample_req = 1'b0;
        va0 = 7'h00; va1 = 7'h00; vb0 = 7'h00; vb1 = 7'h00;
        repeat (3) @(negedge clk);

        chk("rst_ch_sel",      32'(ifa.ch_sel),      32'd0);
        chk("rst_sample_hold", 32'(ifa.sample_hold), 32'd0);
        chk("rst_dac_code",    32'(ifa.dac_code),    32'h00);
        chk("rst_m_sense",     32'(ifa.m_sense),     32'h7F);
        chk("rst_m_thresh",    32'(ifa.m_thresh),    32'h00);
        chk("rst_data_valid",  32'(ifa.data_valid),  32'd0);
        chk("rst_busy",        32'(ifa.busy),        32'd0);
        chk("rst_b_m_sense",   32'(ifb.m_sense),     32'h7F);
        rst = 1'b0;
        @(negedge clk);

        // Basic scan 0x55 / 0x2A.
        va0 = 7'h55; va1 = 7'h2A;
        request(0, 7'h55, 7'h2A, 1'b1);
        chk("accept_busy",        32'(ifa.busy),        32'd1);
        chk("accept_sample_hold", 32'(ifa.sample_hold), 32'd1);
        chk("accept_ch_sel",      32'(ifa.ch_sel),      32'd0);
        chk("accept_dac_code",    32'(ifa.dac_code),    32'h00);
        wait_done(0, 60);
        chk("idle_dac_code", 32'(ifa.dac_code), 32'h00);

        // Full-scale / zero-scale, with channel-0 trial code sequence.
        va0 = 7'h7F; va1 = 7'h00;
        cap = 1'b1;
        @(negedge clk);
        seq.delete();
        request(0, 7'h7F, 7'h00, 1'b1);
        wait_done(0, 60);
        cap = 1'b0;
        chk("seq_len", 32'(seq.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < seq.size()) chk($sformatf("seq_code_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
        end

        // Request held high: a new scan only from IDLE, one data_valid every 38 cycles.
        @(negedge clk);
        va0 = 7'h33; va1 = 7'h4C;
        n0 = cyc;
        for (int k = 0; k < 3; k++) q.push_back('{0, 7'h33, 7'h4C, n0 + 37 + 38 * k});
        ifa.sample_req = 1'b1;
        repeat (114) @(negedge clk);
        ifa.sample_req = 1'b0;
        chk("held_idle_busy", 32'(ifa.busy), 32'd0);
        chk("held_pending",   32'(q.size()), 32'd0);
        @(negedge clk);

        // Extra requests at cycles 10 and 37 after acceptance are ignored.
        va0 = 7'h12; va1 = 7'h6B;
        request(0, 7'h12, 7'h6B, 1'b1);
        repeat (9) @(negedge clk);
        ifa.sample_req = 1'b1;
        @(negedge clk);
        ifa.sample_req = 1'b0;
        repeat (26) @(negedge clk);
        ifa.sample_req = 1'b1;
        @(negedge clk);
        ifa.sample_req = 1'b0;
        chk("extra_idle_busy", 32'(ifa.busy), 32'd0);
        repeat (45) @(negedge clk);
        chk("extra_no_restart", 32'(ifa.busy), 32'd0);
        chk("extra_pending",    32'(q.size()), 32'd0);

        // Reset while channel 1 settles aborts without a result.
        va0 = 7'h55; va1 = 7'h2A;
        request(0, 7'h00, 7'h00, 1'b0);
        repeat (19) @(negedge clk);
        chk("abort_ch1_sel",    32'(ifa.ch_sel),  32'd1);
        chk("abort_mid_sense",  32'(ifa.m_sense), 32'h55);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_m_sense",    32'(ifa.m_sense),    32'h7F);
        chk("abort_m_thresh",   32'(ifa.m_thresh),   32'h00);
        chk("abort_busy",       32'(ifa.busy),       32'd0);
        chk("abort_data_valid", 32'(ifa.data_valid), 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", 32'(ifa.busy), 32'd0);
        request(0, 7'h55, 7'h2A, 1'b1);
        wait_done(0, 60);

        // Minimum timing instance.
        @(negedge clk);
        vb0 = 7'h01; vb1 = 7'h40;
        request(1, 7'h01, 7'h40, 1'b1);
        wait_done(1, 40);
        repeat (3) @(negedge clk);

        chk("final_pending", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
